// File: rtl/soi_probe_pkg.sv
// Shared types and defaults for the signal-of-interest probe.
package soi_probe_pkg;

    // Default width of command argument, cycle counters and response data
    localparam int SOI_CNT_W = 16;

    // Host command opcodes; encodings 5-7 are illegal
    typedef enum logic [2:0] {
        OP_READ    = 3'd0,
        OP_SET0    = 3'd1,
        OP_SET1    = 3'd2,
        OP_RELEASE = 3'd3,
        OP_WATCH   = 3'd4
    } op_t;

    // Probe controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FORCE = 2'd1,
        ST_WATCH = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/soi_edge_counter.sv
// Saturating counter of cycles where soi_in differs from its previous value.
module soi_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             soi_in,
    output logic [CNT_W-1:0] count
);

    logic prev;

    // Clear captures the reference value; each enabled cycle compares and re-captures
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            prev  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            prev  <= soi_in;
        end else if (enable) begin
            prev <= soi_in;
            if ((soi_in != prev) && (count != '1)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/soi_probe.sv
// Debug probe: reads, forces and watches a single signal of interest under host commands.
module soi_probe
    import soi_probe_pkg::*;
#(
    parameter int CNT_W = SOI_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] rsp_data,
    output logic             rsp_err,
    input  logic             soi_in,
    output logic             soi_force_en,
    output logic             soi_force_val
);

    state_t           state;
    state_t           state_nx;
    op_t              op;
    logic             accept;
    logic             last_cycle;
    logic             edge_clear;
    logic             edge_enable;
    logic             watch_sel;
    logic             err_q;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] data_q;
    logic [CNT_W-1:0] edge_count;

    assign op         = op_t'(cmd_op);
    assign cmd_ready  = (state == ST_IDLE);
    assign accept     = cmd_valid & cmd_ready;
    assign last_cycle = (remaining == CNT_W'(1));
    assign rsp_valid  = (state == ST_RESP);
    assign rsp_err    = err_q;
    assign rsp_data   = watch_sel ? edge_count : data_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection and edge-counter control
    always_comb begin
        state_nx    = state;
        edge_clear  = 1'b0;
        edge_enable = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_SET0, OP_SET1: state_nx = (cmd_arg == '0) ? ST_RESP : ST_FORCE;
                        OP_WATCH: begin
                            edge_clear = 1'b1;
                            state_nx   = (cmd_arg == '0) ? ST_RESP : ST_WATCH;
                        end
                        default: state_nx = ST_RESP;
                    endcase
                end
            end
            ST_FORCE: begin
                if (last_cycle) state_nx = ST_RESP;
            end
            ST_WATCH: begin
                edge_enable = 1'b1;
                if (last_cycle) state_nx = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Command capture, force drive, cycle countdown and response payload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining     <= '0;
            data_q        <= '0;
            watch_sel     <= 1'b0;
            err_q         <= 1'b0;
            soi_force_en  <= 1'b0;
            soi_force_val <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        remaining <= cmd_arg;
                        data_q    <= '0;
                        watch_sel <= 1'b0;
                        err_q     <= 1'b0;
                        case (op)
                            OP_READ: data_q <= {{(CNT_W-1){1'b0}}, soi_in};
                            OP_SET0, OP_SET1: begin
                                soi_force_en  <= 1'b1;
                                soi_force_val <= (op == OP_SET1);
                                data_q        <= cmd_arg;
                            end
                            OP_RELEASE: begin
                                soi_force_en  <= 1'b0;
                                soi_force_val <= 1'b0;
                            end
                            OP_WATCH: watch_sel <= 1'b1;
                            default:  err_q <= 1'b1;
                        endcase
                    end
                end
                ST_FORCE: begin
                    remaining <= remaining - 1'b1;
                    if (last_cycle) begin
                        soi_force_en  <= 1'b0;
                        soi_force_val <= 1'b0;
                    end
                end
                ST_WATCH: begin
                    remaining <= remaining - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    soi_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (edge_clear),
        .enable (edge_enable),
        .soi_in (soi_in),
        .count  (edge_count)
    );

endmodule

// File: doc/soi_probe.md
SOI_PROBE -- requirements
Module: soi_probe

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of command argument, cycle counters and response data.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  host command present.
REQ-005 SHALL have port cmd_ready  output  1  block accepts command this cycle.
REQ-006 SHALL have port cmd_op  input  3  opcode: 0 READ, 1 SET0, 2 SET1, 3 RELEASE, 4 WATCH, 5-7 illegal.
REQ-007 SHALL have port cmd_arg  input  CNT_W  cycle count for SET0/SET1/WATCH; ignored otherwise.
REQ-008 SHALL have port rsp_valid  output  1  response present.
REQ-009 SHALL have port rsp_ready  input  1  host accepts response.
REQ-010 SHALL have port rsp_data  output  CNT_W  response payload.
REQ-011 SHALL have port rsp_err  output  1  illegal opcode flag.
REQ-012 SHALL have port soi_in  input  1  observed signal-of-interest value.
REQ-013 SHALL have port soi_force_en  output  1  override enable to target.
REQ-014 SHALL have port soi_force_val  output  1  override value to target.

Function
REQ-015 SHALL implement FSM states IDLE, FORCE, WATCH, RESP; cmd_ready = 1 only in IDLE; handshake = cmd_valid & cmd_ready.
REQ-016 SHALL, on READ accepted at cycle t, register soi_in at t and present rsp_data = zero-extended value with rsp_valid at t+1.
REQ-017 SHALL, on SET0/SET1 with cmd_arg = 0, set persistent force (soi_force_en = 1, soi_force_val = op==SET1) from t+1 and respond rsp_data = 0 at t+1.
REQ-018 SHALL, on SET0/SET1 with cmd_arg = N > 0, enter FORCE, drive force for cycles t+1..t+N, deassert soi_force_en at t+N+1, respond rsp_data = N at t+N+1.
REQ-019 SHALL, at expiry of a timed force, release force entirely, including any previously persistent force.
REQ-020 SHALL, on RELEASE, deassert soi_force_en from t+1 and respond rsp_data = 0 at t+1; RELEASE with no active force is legal and identical.
REQ-021 SHALL, on WATCH with cmd_arg = N > 0, load prev = soi_in at t, count cycles t+1..t+N where soi_in != prev (prev updated every cycle), respond rsp_data = count at t+N+1.
REQ-022 SHALL saturate the transition count at 2^CNT_W-1; WATCH with N = 0 responds rsp_data = 0 at t+1.
REQ-023 SHALL leave a persistent force unchanged during READ and WATCH; READ/WATCH observe soi_in as driven, not soi_force_val.
REQ-024 SHALL, on illegal opcode, respond rsp_err = 1, rsp_data = 0 at t+1 with no other effect; rsp_err = 0 for all legal ops.
REQ-025 SHALL hold rsp_valid, rsp_data, rsp_err stable in RESP until rsp_ready = 1, then return to IDLE the following cycle (cmd_ready = 1 at that cycle).
REQ-026 SHALL not accept a new command in the cycle a response is consumed (no bypass); throughput at most one command per two cycles.
REQ-027 SHALL ignore cmd_valid outside IDLE; cmd_op/cmd_arg sampled only at handshake.

Reset
REQ-028 SHALL, when rst_n = 0 at a rising edge, enter IDLE with cmd_ready = 1 next cycle, rsp_valid = 0, rsp_data = 0, rsp_err = 0, soi_force_en = 0, soi_force_val = 0, counters = 0.
REQ-029 SHALL, on reset mid-FORCE, mid-WATCH or in RESP, drop the pending response and release any force.

Structure
REQ-030 SHALL place opcode enum, FSM state enum and CNT_W default in shared package soi_probe_pkg.
REQ-031 SHALL implement the saturating transition counter as sub-module soi_edge_counter (clear, enable, soi_in, count).

Verification
REQ-032 SHALL cover: soi_in = 1, READ -> rsp_valid next cycle, rsp_data = 1, rsp_err = 0.
REQ-033 SHALL cover: SET1 arg 5, rsp_ready = 1 -> soi_force_en high exactly 5 cycles, force_val = 1, rsp_data = 5 one cycle after release.
REQ-034 SHALL cover: soi_in toggling every cycle, WATCH arg 10 -> rsp_data = 10; soi_in constant, WATCH arg 10 -> rsp_data = 0; CNT_W = 4, WATCH arg 15 under toggling -> rsp_data = 15 (saturated path exercised with arg 15 and extra toggle at accept).
REQ-035 SHALL cover: SET0 arg 0, READ, RELEASE -> force_en stays 1 through READ, drops cycle after RELEASE accept; each response rsp_data = 0 except READ.
REQ-036 SHALL cover: op 6 -> rsp_err = 1, rsp_data = 0; rsp_ready held low 4 cycles -> response stable, cmd_ready = 0.
REQ-037 SHALL cover: rst_n low during FORCE with arg 20 at cycle 3 -> next cycle soi_force_en = 0, rsp_valid = 0, cmd_ready = 1.
